// File: rtl/row_mem_pkg.sv
// Shared widths, limits and FSM encoding for the row memory reader.
package row_mem_pkg;

    localparam int NUM_IA_ROW_MEM_DEF      = 96;
    localparam int NUM_WEIGHT_ROW_MEM_DEF  = 3;
    localparam int INPUT_BW_DEF            = 8;
    localparam int IA_ROW_MEM_ADDR_DEF     = 6;
    localparam int WEIGHT_ROW_MEM_ADDR_DEF = 7;

    localparam int K_W     = 3;
    localparam int IMG_W_W = 6;

    // Physical depth of an IA row memory; addresses at or above it are out of range.
    localparam int IA_ROW_MAX_DEPTH = 34;
    // Wide enough for the largest ow*STRIDE + kw (63*7 + 7).
    localparam int IA_FULL_ADDR_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } row_state_t;

endpackage

// File: rtl/row_mem_addr_gen.sv
// kw/ow loop counters and IA/weight address arithmetic for one row pass.
// ROW_MEM_READER_BOUND_CHECK_EN: keeps a wide IA address and flags entries >= IA_ROW_MAX_DEPTH.
module row_mem_addr_gen
    import row_mem_pkg::*;
#(
    parameter int IA_ADDR_W = IA_ROW_MEM_ADDR_DEF,
    parameter int W_ADDR_W  = WEIGHT_ROW_MEM_ADDR_DEF
)(
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 load,
    input  logic                 advance,
    input  logic [K_W-1:0]       k,
    input  logic [K_W-1:0]       stride,
    input  logic [IMG_W_W-1:0]   img_w,
    input  logic [W_ADDR_W-1:0]  weight_base,
    output logic [IA_ADDR_W-1:0] ia_addr,
    output logic                 ia_oob,
    output logic [W_ADDR_W-1:0]  weight_addr,
    output logic                 first,
    output logic                 last,
    output logic                 final_beat
);

`ifdef ROW_MEM_READER_BOUND_CHECK_EN
    localparam int AW = IA_FULL_ADDR_W;
`else
    localparam int AW = IA_ADDR_W;
`endif

    logic [K_W-1:0]      k_reg;
    logic [K_W-1:0]      stride_reg;
    logic [IMG_W_W-1:0]  img_w_reg;
    logic [W_ADDR_W-1:0] weight_base_reg;
    logic [K_W-1:0]      kw_reg;
    logic [IMG_W_W-1:0]  ow_reg;
    // Running ow*STRIDE, so no multiplier is needed.
    logic [AW-1:0]       row_base_reg;
    logic [AW-1:0]       ia_full;

    always_ff @(posedge clk) begin
        if (srst) begin
            k_reg           <= '0;
            stride_reg      <= '0;
            img_w_reg       <= '0;
            weight_base_reg <= '0;
            kw_reg          <= '0;
            ow_reg          <= '0;
            row_base_reg    <= '0;
        end else if (load) begin
            k_reg           <= k;
            stride_reg      <= stride;
            img_w_reg       <= img_w;
            weight_base_reg <= weight_base;
            kw_reg          <= '0;
            ow_reg          <= '0;
            row_base_reg    <= '0;
        end else if (advance) begin
            if (last) begin
                kw_reg       <= '0;
                ow_reg       <= ow_reg + IMG_W_W'(1);
                row_base_reg <= row_base_reg + AW'(stride_reg);
            end else begin
                kw_reg <= kw_reg + K_W'(1);
            end
        end
    end

    assign ia_full     = row_base_reg + AW'(kw_reg);
    assign ia_addr     = IA_ADDR_W'(ia_full);
    assign weight_addr = weight_base_reg + W_ADDR_W'(kw_reg);
    assign first       = (kw_reg == '0);
    assign last        = (kw_reg == (k_reg - K_W'(1)));
    assign final_beat  = last && (ow_reg == (img_w_reg - IMG_W_W'(1)));

`ifdef ROW_MEM_READER_BOUND_CHECK_EN
    assign ia_oob = (ia_full >= AW'(IA_ROW_MAX_DEPTH));
`else
    assign ia_oob = 1'b0;
`endif

endmodule

// File: rtl/row_mem_reader.sv
// Row pass reader: walks kw/ow over the IA and weight row mems and streams PE-array beats.
// ROW_MEM_READER_BOUND_CHECK_EN: suppresses IA reads at out-of-range addresses and zeroes those beats.
module row_mem_reader
    import row_mem_pkg::*;
#(
    parameter int NUM_IA_ROW_MEM      = NUM_IA_ROW_MEM_DEF,
    parameter int NUM_WEIGHT_ROW_MEM  = NUM_WEIGHT_ROW_MEM_DEF,
    parameter int INPUT_BW            = INPUT_BW_DEF,
    parameter int IA_ROW_MEM_ADDR     = IA_ROW_MEM_ADDR_DEF,
    parameter int WEIGHT_ROW_MEM_ADDR = WEIGHT_ROW_MEM_ADDR_DEF
)(
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [K_W-1:0]                         K,
    input  logic [K_W-1:0]                         STRIDE,
    input  logic [IMG_W_W-1:0]                     IMG_W,
    input  logic [WEIGHT_ROW_MEM_ADDR-1:0]         WEIGHT_BASE,
    output logic                                   busy,
    output logic                                   done,
    output logic [NUM_IA_ROW_MEM-1:0]              ia_row_mem_enb,
    output logic [IA_ROW_MEM_ADDR-1:0]             ia_row_mem_addrb,
    input  logic [NUM_IA_ROW_MEM*INPUT_BW-1:0]     ia_row_mem_doutb_flat,
    output logic [NUM_WEIGHT_ROW_MEM-1:0]          weight_row_mem_enb,
    output logic [WEIGHT_ROW_MEM_ADDR-1:0]         weight_row_mem_addrb,
    input  logic [NUM_WEIGHT_ROW_MEM*INPUT_BW-1:0] weight_row_mem_doutb_flat,
    output logic [NUM_IA_ROW_MEM*INPUT_BW-1:0]     act_out_flat,
    output logic [NUM_WEIGHT_ROW_MEM*INPUT_BW-1:0] weight_out_flat,
    output logic                                   out_valid,
    output logic                                   out_first,
    output logic                                   out_last
);

    row_state_t state_reg, state_next;
    logic       drain_cnt_reg, drain_cnt_next;
    logic       load;
    logic       read_active;

    logic [IA_ROW_MEM_ADDR-1:0]     gen_ia_addr;
    logic [WEIGHT_ROW_MEM_ADDR-1:0] gen_weight_addr;
    logic                           gen_oob;
    logic                           gen_first;
    logic                           gen_last;
    logic                           gen_final;

    // Stage 1 tracks the memory read cycle, stage 2 is the output register.
    logic v1_reg, first1_reg, last1_reg, oob1_reg;
    logic out_valid_reg, out_first_reg, out_last_reg;
    logic [INPUT_BW-1:0]                     act_reg [NUM_IA_ROW_MEM];
    logic [NUM_WEIGHT_ROW_MEM*INPUT_BW-1:0]  weight_reg;

    assign load        = (state_reg == ST_IDLE) && start;
    assign read_active = (state_reg == ST_READ);

    row_mem_addr_gen #(
        .IA_ADDR_W (IA_ROW_MEM_ADDR),
        .W_ADDR_W  (WEIGHT_ROW_MEM_ADDR)
    ) u_addr_gen (
        .clk         (clk),
        .srst        (reset),
        .load        (load),
        .advance     (read_active),
        .k           (K),
        .stride      (STRIDE),
        .img_w       (IMG_W),
        .weight_base (WEIGHT_BASE),
        .ia_addr     (gen_ia_addr),
        .ia_oob      (gen_oob),
        .weight_addr (gen_weight_addr),
        .first       (gen_first),
        .last        (gen_last),
        .final_beat  (gen_final)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            drain_cnt_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if ((K != '0) && (IMG_W != '0)) begin
                        state_next = ST_READ;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                if (gen_final) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Two cycles let the last beat clear the read and output stages.
                drain_cnt_next = 1'b1;
                if (drain_cnt_reg) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_reg != ST_IDLE);
    assign done = (state_reg == ST_DONE);

    assign ia_row_mem_addrb     = read_active ? gen_ia_addr : '0;
    assign weight_row_mem_addrb = read_active ? gen_weight_addr : '0;

    generate
        for (genvar gi = 0; gi < NUM_IA_ROW_MEM; gi++) begin : g_ia_enb
            assign ia_row_mem_enb[gi] = read_active & ~gen_oob;
        end
        for (genvar gi = 0; gi < NUM_WEIGHT_ROW_MEM; gi++) begin : g_w_enb
            assign weight_row_mem_enb[gi] = read_active;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_reg        <= 1'b0;
            first1_reg    <= 1'b0;
            last1_reg     <= 1'b0;
            oob1_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            out_first_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            weight_reg    <= '0;
        end else begin
            v1_reg        <= read_active;
            first1_reg    <= read_active & gen_first;
            last1_reg     <= read_active & gen_last;
            oob1_reg      <= read_active & gen_oob;
            out_valid_reg <= v1_reg;
            out_first_reg <= first1_reg;
            out_last_reg  <= last1_reg;
            if (v1_reg) begin
                weight_reg <= weight_row_mem_doutb_flat;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_IA_ROW_MEM; gi++) begin : g_act
            always_ff @(posedge clk) begin
                if (reset) begin
                    act_reg[gi] <= '0;
                end else if (v1_reg) begin
                    // An out-of-range read was never enabled, so its stale data is masked.
                    act_reg[gi] <= oob1_reg ? '0
                                            : ia_row_mem_doutb_flat[gi*INPUT_BW +: INPUT_BW];
                end
            end
            assign act_out_flat[gi*INPUT_BW +: INPUT_BW] = act_reg[gi];
        end
    endgenerate

    assign weight_out_flat = weight_reg;
    assign out_valid       = out_valid_reg;
    assign out_first       = out_first_reg;
    assign out_last        = out_last_reg;

endmodule
